// File: rtl/minterm_sweep_checker.sv
// Exhaustive self-sequencing tester for an N-input combinational function: sweeps every
// input vector, samples f after SETTLE cycles and compares the captured minterm map.
module minterm_sweep_checker #(
    parameter int unsigned N      = 4,
    parameter int unsigned SETTLE = 2
) (
    input  logic                clk,
    input  logic                reset_b,
    input  logic                start,
    input  logic [(1<<N)-1:0]   expected,
    input  logic                dut_f,
    output logic [N-1:0]        dut_in,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [(1<<N)-1:0]   captured,
    output logic [N:0]          mismatch_count,
    output logic                fail_valid,
    output logic [N-1:0]        first_fail
);
    localparam int unsigned M  = 1 << N;
    localparam int unsigned CW = 8;
    localparam int unsigned MW = N + 1;
    localparam logic [CW-1:0] SETTLE_RELOAD = CW'(SETTLE - 1);
    localparam logic [N-1:0]  LAST_VEC      = N'(M - 1);

    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, FINISH} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   settle_q, settle_d;
    logic [M-1:0]    exp_q, exp_d;
    logic [N-1:0]    dut_in_d;
    logic            busy_d, done_d, pass_d, fail_valid_d;
    logic [M-1:0]    captured_d;
    logic [MW-1:0]   mismatch_d;
    logic [N-1:0]    first_fail_d;

    // State and registered outputs
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q        <= IDLE;
            settle_q       <= '0;
            exp_q          <= '0;
            dut_in         <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            captured       <= '0;
            mismatch_count <= '0;
            fail_valid     <= 1'b0;
            first_fail     <= '0;
        end else begin
            state_q        <= state_d;
            settle_q       <= settle_d;
            exp_q          <= exp_d;
            dut_in         <= dut_in_d;
            busy           <= busy_d;
            done           <= done_d;
            pass           <= pass_d;
            captured       <= captured_d;
            mismatch_count <= mismatch_d;
            fail_valid     <= fail_valid_d;
            first_fail     <= first_fail_d;
        end
    end

    // Sweep sequencing and result accumulation
    always_comb begin
        state_d      = state_q;
        settle_d     = settle_q;
        exp_d        = exp_q;
        dut_in_d     = dut_in;
        busy_d       = busy;
        done_d       = 1'b0;
        pass_d       = pass;
        captured_d   = captured;
        mismatch_d   = mismatch_count;
        fail_valid_d = fail_valid;
        first_fail_d = first_fail;

        case (state_q)
            IDLE: begin
                if (start) begin
                    exp_d        = expected;
                    captured_d   = '0;
                    mismatch_d   = '0;
                    fail_valid_d = 1'b0;
                    first_fail_d = '0;
                    pass_d       = 1'b0;
                    dut_in_d     = '0;
                    settle_d     = SETTLE_RELOAD;
                    busy_d       = 1'b1;
                    state_d      = DRIVE;
                end
            end
            DRIVE: begin
                if (settle_q != '0) begin
                    settle_d = settle_q - CW'(1);
                end else begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                captured_d[dut_in] = dut_f;
                if (dut_f != exp_q[dut_in]) begin
                    mismatch_d = mismatch_count + MW'(1);
                    if (!fail_valid) begin
                        first_fail_d = dut_in;
                        fail_valid_d = 1'b1;
                    end
                end
                // busy drops as FINISH is entered so it spans exactly 2^N*(SETTLE+1) cycles
                if (dut_in == LAST_VEC) begin
                    busy_d  = 1'b0;
                    state_d = FINISH;
                end else begin
                    dut_in_d = dut_in + N'(1);
                    settle_d = SETTLE_RELOAD;
                    state_d  = DRIVE;
                end
            end
            FINISH: begin
                done_d  = 1'b1;
                pass_d  = (mismatch_count == '0);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_minterm_sweep_checker.sv
// Bench for minterm_sweep_checker: cycle model of a N=4/SETTLE=2 sweep checked every cycle,
// plus hand-computed expectations for each scenario and a small N=2/SETTLE=1 instance.
module tb_minterm_sweep_checker;
    logic        clk = 1'b0;
    logic        reset_b = 1'b1;
    logic        start = 1'b0;
    logic [15:0] expected = 16'h6996;
    logic        dut_f;
    logic [3:0]  dut_in;
    logic        busy, done, pass, fail_valid;
    logic [15:0] captured;
    logic [4:0]  mismatch_count;
    logic [3:0]  first_fail;

    logic        start2 = 1'b0;
    logic [3:0]  expected2 = 4'b1000;
    logic        dut2_f;
    logic [1:0]  dut2_in;
    logic        busy2, done2, pass2, fail_valid2;
    logic [3:0]  captured2;
    logic [2:0]  mismatch_count2;
    logic [1:0]  first_fail2;

    int n_cmp = 0;
    int n_bad = 0;
    int mode = 0;      // 0: a^b^c^d, 1: stuck at 0, 2: ~(a^b^c^d)
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    minterm_sweep_checker #(.N(4), .SETTLE(2)) u_dut (
        .clk(clk), .reset_b(reset_b), .start(start), .expected(expected), .dut_f(dut_f),
        .dut_in(dut_in), .busy(busy), .done(done), .pass(pass), .captured(captured),
        .mismatch_count(mismatch_count), .fail_valid(fail_valid), .first_fail(first_fail)
    );

    minterm_sweep_checker #(.N(2), .SETTLE(1)) u_dut2 (
        .clk(clk), .reset_b(reset_b), .start(start2), .expected(expected2), .dut_f(dut2_f),
        .dut_in(dut2_in), .busy(busy2), .done(done2), .pass(pass2), .captured(captured2),
        .mismatch_count(mismatch_count2), .fail_valid(fail_valid2), .first_fail(first_fail2)
    );

    function automatic bit fref(input int k, input int md);
        logic [3:0] v;
        v = 4'(k);
        if (md == 1) return 1'b0;
        if (md == 2) return ~(^v);
        return ^v;
    endfunction

    always_comb dut_f = fref(int'(dut_in), mode);
    always_comb dut2_f = &dut2_in;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: m_e counts clock edges since the accepted start edge; a sweep is 16 vectors of 3 cycles
    bit          m_run = 1'b0;
    int          m_e = 0;
    int          m_mode = 0;
    logic [15:0] m_exp = '0;

    always @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            m_run <= 1'b0;
            m_e   <= 0;
            m_exp <= '0;
        end else if (start && (!m_run || m_e >= 49)) begin
            m_run  <= 1'b1;
            m_e    <= 0;
            m_exp  <= expected;
            m_mode <= mode;
        end else if (m_run && m_e < 1000) begin
            m_e <= m_e + 1;
        end
    end

    always @(negedge clk) begin : cmp
        int          ns, e_mis, e_ff, e_in;
        bit          e_fv, e_busy, e_done, e_pass;
        logic [15:0] e_cap;
        if (cmp_en && reset_b) begin
            e_cap = '0; e_mis = 0; e_ff = 0; e_fv = 1'b0;
            e_busy = 1'b0; e_done = 1'b0; e_pass = 1'b0; e_in = 0;
            if (m_run) begin
                ns     = (m_e / 3 > 16) ? 16 : m_e / 3;
                e_in   = (m_e / 3 > 15) ? 15 : m_e / 3;
                e_busy = (m_e < 48);
                e_done = (m_e == 49);
                for (int k = 0; k < 16; k++) begin
                    if (k < ns) begin
                        e_cap[k] = fref(k, m_mode);
                        if (e_cap[k] != m_exp[k]) begin
                            if (!e_fv) e_ff = k;
                            e_fv = 1'b1;
                            e_mis++;
                        end
                    end
                end
                e_pass = (m_e >= 49) && (e_mis == 0);
            end
            chk("cyc_dut_in", 32'(dut_in), 32'(e_in));
            chk("cyc_busy", 32'(busy), 32'(e_busy));
            chk("cyc_done", 32'(done), 32'(e_done));
            chk("cyc_pass", 32'(pass), 32'(e_pass));
            chk("cyc_captured", 32'(captured), 32'(e_cap));
            chk("cyc_mismatch_count", 32'(mismatch_count), 32'(e_mis));
            chk("cyc_fail_valid", 32'(fail_valid), 32'(e_fv));
            chk("cyc_first_fail", 32'(first_fail), 32'(e_ff));
        end
    end

    task automatic chk_zero(input string tag);
        chk({tag, "_dut_in"}, 32'(dut_in), 32'h0);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
        chk({tag, "_done"}, 32'(done), 32'h0);
        chk({tag, "_pass"}, 32'(pass), 32'h0);
        chk({tag, "_captured"}, 32'(captured), 32'h0);
        chk({tag, "_mismatch_count"}, 32'(mismatch_count), 32'h0);
        chk({tag, "_fail_valid"}, 32'(fail_valid), 32'h0);
        chk({tag, "_first_fail"}, 32'(first_fail), 32'h0);
    endtask

    // ev: 0 plain, 1 restart + expected change at cycle 10, 2 reset at cycle 20, 3 start held 45..50
    task automatic sweep(input int ev, output int d1, output int d2);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        d1 = -1; d2 = -1;
        for (int i = 1; i <= 120; i++) begin
            @(posedge clk); #1;
            if (done) begin
                if (d1 < 0) d1 = i;
                else if (d2 < 0) d2 = i;
            end
            if (ev == 1 && i == 10) begin start = 1'b1; expected = 16'hFFFF; end
            if (ev == 1 && i == 11) start = 1'b0;
            if (ev == 3 && i == 45) start = 1'b1;
            if (ev == 3 && i == 51) start = 1'b0;
            if (ev == 2 && i == 20) begin
                reset_b = 1'b0;
                #1;
                chk_zero("async_reset");
            end
            if (ev == 2 && i == 23) reset_b = 1'b1;
        end
    endtask

    task automatic chk_result(input string tag, input logic [15:0] cap, input int mis,
                              input int ff, input bit fv, input bit ps);
        chk({tag, "_captured"}, 32'(captured), 32'(cap));
        chk({tag, "_mismatch_count"}, 32'(mismatch_count), 32'(mis));
        chk({tag, "_first_fail"}, 32'(first_fail), 32'(ff));
        chk({tag, "_fail_valid"}, 32'(fail_valid), 32'(fv));
        chk({tag, "_pass"}, 32'(pass), 32'(ps));
    endtask

    int d1, d2, d_small;
    int seq[8];
    int exp_seq[8] = '{0, 0, 1, 1, 2, 2, 3, 3};

    initial begin
        #2 reset_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        reset_b = 1'b1;
        cmp_en = 1'b1;

        mode = 0;
        sweep(0, d1, d2);
        chk("xor_done_edge", 32'(d1), 32'd49);
        chk("xor_single_done", 32'(d2), 32'hFFFF_FFFF);
        chk_result("xor", 16'h6996, 0, 0, 1'b0, 1'b1);
        chk("xor_dut_in_hold", 32'(dut_in), 32'hF);

        mode = 1;
        sweep(0, d1, d2);
        chk("stuck0_done_edge", 32'(d1), 32'd49);
        chk_result("stuck0", 16'h0000, 8, 1, 1'b1, 1'b0);

        mode = 2;
        sweep(0, d1, d2);
        chk("xnor_done_edge", 32'(d1), 32'd49);
        chk_result("xnor", 16'h9669, 16, 0, 1'b1, 1'b0);

        mode = 0;
        sweep(1, d1, d2);
        expected = 16'h6996;
        chk("restart_done_edge", 32'(d1), 32'd49);
        chk("restart_single_done", 32'(d2), 32'hFFFF_FFFF);
        chk_result("restart", 16'h6996, 0, 0, 1'b0, 1'b1);

        mode = 1;
        sweep(2, d1, d2);
        chk("reset_no_done", 32'(d1), 32'hFFFF_FFFF);
        chk_zero("after_abort");

        mode = 0;
        sweep(0, d1, d2);
        chk("fresh_done_edge", 32'(d1), 32'd49);
        chk_result("fresh", 16'h6996, 0, 0, 1'b0, 1'b1);

        mode = 1;
        sweep(3, d1, d2);
        chk("held_first_done", 32'(d1), 32'd49);
        chk("held_second_done", 32'(d2), 32'd99);
        chk_result("held", 16'h0000, 8, 1, 1'b1, 1'b0);

        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        seq[0] = int'(dut2_in);
        d_small = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (i < 8) seq[i] = int'(dut2_in);
            if (done2 && d_small < 0) d_small = i;
        end
        for (int k = 0; k < 8; k++) chk("small_dut_in_seq", 32'(seq[k]), 32'(exp_seq[k]));
        chk("small_done_edge", 32'(d_small), 32'd9);
        chk("small_captured", 32'(captured2), 32'h8);
        chk("small_pass", 32'(pass2), 32'h1);
        chk("small_mismatch_count", 32'(mismatch_count2), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
